instr_fetch: RTL and testbench

//  Fetch stage between the program counter and the instruction decoder/control unit.
//  - Drives the PC's increment strobe.
//  - Issues synchronous reads to instruction memory and buffers the returned words.
//  - Presents each instruction, with its address, to the decoder over a valid/ready handshake.
//  - Flushes all buffered and in-flight fetches when a taken jump redirects the PC.

---
 rtl/proc_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 53 +++++
 rtl/instr_fetch.sv | 77 +++++++
 tb/tb_instr_fetch.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions: datapath widths, well-known PC values and the fetch buffer payload.
package proc_pkg;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 16;

  localparam logic [PC_W-1:0] RESET_PC      = 16'h0000;
  localparam logic [PC_W-1:0] LOOP_START_PC = 16'h0003;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer holding {instruction, address} pairs; flush empties it at the edge.
module fetch_fifo
  import proc_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 flush_keep_none,
  input  fetch_entry_t         din,
  output fetch_entry_t         head,
  output logic [CNT_W-1:0]     count,
  output logic                 empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & ~flush_keep_none;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush_keep_none) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: credit-limited imem reads, tag tracking, buffered delivery to decode, redirect flush.
module instr_fetch
  import proc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_W-1:0]    pc,
  output logic               pc_inc,
  input  logic               redirect,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CRD_W = CNT_W + 1;

  logic [CNT_W-1:0] count;
  logic             empty;
  fetch_entry_t     head;
  fetch_entry_t     push_data;
  logic             inflight;
  logic [PC_W-1:0]  tag;
  logic             deq;
  logic             issue;
  logic             push;
  logic [CRD_W-1:0] occupancy;

  assign instr_valid = ~empty;
  assign deq         = instr_valid & instr_ready;

  // Buffered plus in-flight entries, net of this cycle's dequeue, must leave room for one more.
  assign occupancy = CRD_W'(count) + CRD_W'(inflight) - CRD_W'(deq);
  assign issue     = ~reset & ~redirect & (occupancy < CRD_W'(FIFO_DEPTH));

  assign pc_inc    = issue;
  assign imem_en   = issue;
  assign imem_addr = pc;

  assign push            = inflight & ~redirect;
  assign push_data.instr = imem_rdata;
  assign push_data.pc    = tag;

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= 1'b0;
      tag      <= RESET_PC;
    end else begin
      inflight <= issue;
      if (issue) tag <= pc;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk             (clk),
    .reset           (reset),
    .push            (push),
    .pop             (deq),
    .flush_keep_none (redirect),
    .din             (push_data),
    .head            (head),
    .count           (count),
    .empty           (empty)
  );

  assign instr    = instr_valid ? head.instr : '0;
  assign instr_pc = instr_valid ? head.pc    : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: PC and imem models, expected-address queue, decoupled monitor.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc;
  logic        pc_inc;
  logic        redirect = 1'b0;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_issue = 0;

  logic [15:0] exp_q [$];

  instr_fetch #(.FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .pc_inc      (pc_inc),
    .redirect    (redirect),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  // PC block model: jumps go to 0x0003.
  always @(posedge clk) begin
    if (reset)         pc <= 16'h0000;
    else if (redirect) pc <= 16'h0003;
    else if (pc_inc)   pc <= pc + 16'h0001;
  end

  // Instruction memory: one-cycle read; garbage when not enabled.
  always @(posedge clk) begin
    imem_rdata <= imem_en ? (imem_addr ^ 16'hA5A5) : 16'hDEAD;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: compares every accepted instruction against the expected queue.
  logic        hold_v = 1'b0;
  logic [15:0] hold_instr;
  logic [15:0] hold_pc;
  always @(negedge clk) begin
    logic [15:0] e;
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("stall_valid", 32'(instr_valid), 32'd1);
        chk("stall_instr", 32'(instr), 32'(hold_instr));
        chk("stall_pc", 32'(instr_pc), 32'(hold_pc));
      end
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_delivery: got pc %0h, expected none (t=%0t)", instr_pc, $time);
        end else begin
          e = exp_q.pop_front();
          chk("deliv_pc", 32'(instr_pc), 32'(e));
          chk("deliv_instr", 32'(instr), 32'(e ^ 16'hA5A5));
        end
        n_acc++;
      end
      if (imem_en) begin
        n_issue++;
        chk("imem_addr", 32'(imem_addr), 32'(pc));
      end
      chk("en_eq_inc", 32'(imem_en), 32'(pc_inc));
      hold_v     = instr_valid && !instr_ready && !redirect;
      hold_instr = instr;
      hold_pc    = instr_pc;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Two reset edges, reset-state checks, release; returns in cycle 0 after release.
  task automatic do_reset();
    reset    = 1'b1;
    redirect = 1'b0;
    exp_q.delete();
    step();
    @(negedge clk);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);
    chk("rst_pc_inc", 32'(pc_inc), 32'd0);
    chk("rst_imem_en", 32'(imem_en), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int acc0;
    int iss0;
    int next_push;
    logic found;
    logic prev_redir;

    // 1: streaming from reset
    instr_ready = 1'b1;
    do_reset();
    for (int a = 0; a < 18; a++) exp_q.push_back(16'(a));
    acc0 = n_acc;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("t1_valid", 32'(instr_valid), (c >= 2) ? 32'd1 : 32'd0);
      chk("t1_pc_inc", 32'(pc_inc), 32'd1);
      if (c == 2) chk("t1_instr0", 32'(instr), 32'hA5A5);
      if (c == 3) chk("t1_instr1", 32'(instr), 32'hA5A4);
      if (c == 4) chk("t1_instr2", 32'(instr), 32'hA5A7);
      @(posedge clk);
      #1;
    end
    chk("t1_count", 32'(n_acc - acc0), 32'd18);
    chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // 2: stalled from reset, then release
    instr_ready = 1'b0;
    do_reset();
    for (int a = 0; a < 4; a++) exp_q.push_back(16'(a));
    acc0 = n_acc;
    iss0 = n_issue;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("t2_pc_inc", 32'(pc_inc), (c < 2) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    chk("t2_issues", 32'(n_issue - iss0), 32'd2);
    chk("t2_pc_hold", 32'(pc), 32'h0002);
    instr_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t2_b2b_valid", 32'(instr_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    instr_ready = 1'b0;
    chk("t2_count", 32'(n_acc - acc0), 32'd4);
    chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // 3: redirect while 0x0005 is accepted
    instr_ready = 1'b1;
    do_reset();
    for (int a = 0; a < 6; a++) exp_q.push_back(16'(a));
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (instr_valid && instr_pc == 16'h0005) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("t3_reached_5", 32'(found), 32'd1);
    if (found) begin
      redirect = 1'b1;
      #1;
      chk("t3_pc_inc", 32'(pc_inc), 32'd0);
      chk("t3_imem_en", 32'(imem_en), 32'd0);
      @(posedge clk);
      #1;
      redirect = 1'b0;
      chk("t3_q_drained", 32'(exp_q.size()), 32'd0);
      for (int a = 3; a < 13; a++) exp_q.push_back(16'(a));
      acc0 = n_acc;
      @(negedge clk);
      chk("t3_valid_after", 32'(instr_valid), 32'd0);
      @(posedge clk);
      #1;
      repeat (11) step();
      chk("t3_count", 32'(n_acc - acc0), 32'd10);
      chk("t3_q_empty", 32'(exp_q.size()), 32'd0);
    end

    // 4: redirect with a full buffer
    instr_ready = 1'b0;
    do_reset();
    exp_q.push_back(16'h0000);
    repeat (4) step();
    redirect = 1'b1;
    step();
    redirect = 1'b0;
    exp_q.delete();
    exp_q.push_back(16'h0003);
    exp_q.push_back(16'h0004);
    acc0 = n_acc;
    @(negedge clk);
    chk("t4_valid_after", 32'(instr_valid), 32'd0);
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    @(negedge clk);
    chk("t4_gap_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk("t4_first_pc", 32'(instr_pc), 32'h0003);
    chk("t4_first_instr", 32'(instr), 32'hA5A6);
    @(posedge clk);
    #1;
    step();
    instr_ready = 1'b0;
    chk("t4_count", 32'(n_acc - acc0), 32'd2);
    chk("t4_q_empty", 32'(exp_q.size()), 32'd0);

    // 5: one-cycle reset with an entry buffered and a read in flight
    instr_ready = 1'b0;
    do_reset();
    repeat (2) step();
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("t5_rst_imem_en", 32'(imem_en), 32'd0);
    chk("t5_rst_pc_inc", 32'(pc_inc), 32'd0);
    @(posedge clk);
    #1;
    reset       = 1'b0;
    instr_ready = 1'b1;
    for (int a = 0; a < 3; a++) exp_q.push_back(16'(a));
    acc0 = n_acc;
    @(negedge clk);
    chk("t5_valid_after", 32'(instr_valid), 32'd0);
    @(posedge clk);
    #1;
    repeat (4) step();
    instr_ready = 1'b0;
    chk("t5_count", 32'(n_acc - acc0), 32'd3);
    chk("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // 6: random stalls and occasional redirects
    do_reset();
    next_push  = 0;
    prev_redir = 1'b0;
    acc0       = n_acc;
    for (int i = 0; i < 2000; i++) begin
      if (prev_redir) begin
        exp_q.delete();
        next_push = 3;
      end
      while (exp_q.size() < 4) begin
        exp_q.push_back(16'(next_push));
        next_push++;
      end
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 49) == 0);
      prev_redir  = redirect;
      step();
    end
    redirect    = 1'b0;
    instr_ready = 1'b0;
    chk("t6_progress", 32'((n_acc - acc0) > 500), 32'd1);

    reset = 1'b1;
    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
